clock_divider_prog: RTL

- Runtime-programmable integer clock divider. Successor to the fixed divide-by-4 divider.
- Generates a divided clock-enable-style waveform `out_clk` and a one-cycle `tick` strobe from `clk`.
- Divisor is loaded through a shadow register and only takes effect at a period boundary, so ratio changes never produce runt pulses.
- Start/stop is gated by `en`; stopping is deferred to the end of the current period.

---
 rtl/clock_divider_prog_if.sv | 23 ++
 rtl/clock_divider_prog.sv | 129 ++++++++++++
 2 files changed

// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog: run request, divisor load and divider outputs.
interface clock_divider_prog_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             out_clk;
  logic             tick;
  logic [CNT_W-1:0] div_active;
  logic             load_pending;
  logic             running;

  modport master (
    output en, div_val, div_load,
    input  out_clk, tick, div_active, load_pending, running
  );

  modport slave (
    input  en, div_val, div_load,
    output out_clk, tick, div_active, load_pending, running
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with shadowed divisor and period-aligned stop.
// Optional CLKDIV_ODD50_EN adds a falling-edge flop giving exact 50% duty for odd divisors.
module clock_divider_prog #(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 4
) (
  input  logic              clk,
  input  logic              reset,
  clock_divider_prog_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             wrap, boundary;
  logic [CNT_W-1:0] n_eff, h_eff, cnt_next, load_val;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(2)) ? CNT_W'(2) : v;
  endfunction

  // Number of cycles the rising-edge register holds out_clk high in a period of n.
  function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] n);
`ifdef CLKDIV_ODD50_EN
    return n >> 1;
`else
    return n - (n >> 1);
`endif
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= CNT_W'(DIV_RESET);
      shadow_q <= CNT_W'(DIV_RESET);
      pend_q   <= 1'b0;
      out_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      out_q    <= out_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    out_d    = out_q;
    tick_d   = tick_q;
    load_val = clamp_div(bus.div_val);
    wrap     = (state_q == S_RUN) && (cnt_q == div_q - 1'b1);
    boundary = wrap || (state_q == S_IDLE);
    n_eff    = div_q;

    // Divisor changes only land on a period boundary; idle edges count as boundaries.
    if (boundary) begin
      if (bus.div_load) begin
        n_eff    = load_val;
        shadow_d = load_val;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        n_eff  = shadow_q;
        pend_d = 1'b0;
      end
    end else if (bus.div_load) begin
      shadow_d = load_val;
      pend_d   = 1'b1;
    end
    div_d = n_eff;

    cnt_next = wrap ? '0 : cnt_q + 1'b1;
    h_eff    = high_len(n_eff);

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tick_d = 1'b0;
        out_d  = bus.en;
        if (bus.en) state_d = S_RUN;
      end
      default: begin
        if (wrap && !bus.en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
          tick_d  = 1'b0;
        end else begin
          cnt_d  = cnt_next;
          out_d  = (cnt_next < h_eff);
          tick_d = (cnt_next == n_eff - 1'b1);
        end
      end
    endcase
  end

`ifdef CLKDIV_ODD50_EN
  logic neg_q;

  // Extends the high phase by half a clk period when the divisor is odd.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) neg_q <= 1'b0;
    else       neg_q <= out_q & div_q[0];
  end

  assign bus.out_clk = out_q | neg_q;
`else
  assign bus.out_clk = out_q;
`endif

  assign bus.tick         = tick_q;
  assign bus.div_active   = div_q;
  assign bus.load_pending = pend_q;
  assign bus.running      = (state_q == S_RUN);

endmodule
